// File: rtl/sid_bus_pkg.sv
// rtl/sid_bus_pkg.sv - shared types and constants for the SCSI-ID config register bus
package sid_bus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RECOV  = 3'd4
    } sid_state_e;

    localparam logic [7:0] SID_CFG_RESET       = 8'hFF;
    localparam int         SID_DEFAULT_TIMEOUT = 15;

    // Plain-vector state codes for the FSM register.
    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_SETUP  = SETUP;
    localparam logic [2:0] ST_STROBE = STROBE;
    localparam logic [2:0] ST_HOLD   = HOLD;
    localparam logic [2:0] ST_RECOV  = RECOV;

    function automatic logic [7:0] sid_u8(input int v);
        return v[7:0];
    endfunction

endpackage

// File: rtl/sid_bus_initiator_if.sv
// rtl/sid_bus_initiator_if.sv - byte-wide local register bus between initiator and responder
interface sid_bus_initiator_if;
    logic       cyc;
    logic       DOE;
    logic       DS0_n;
    logic       READ;
    logic [7:0] DOUT;
    logic [7:0] DIN;
    logic       dtack;

    modport master (
        output cyc, DOE, DS0_n, READ, DOUT,
        input  DIN, dtack
    );

    modport slave (
        input  cyc, DOE, DS0_n, READ, DOUT,
        output DIN, dtack
    );
endinterface

// File: rtl/sid_timeout_ctr.sv
// rtl/sid_timeout_ctr.sv - loadable 8-bit down-counter with zero flag
module sid_timeout_ctr (
    input  logic       clk,
    input  logic       IORST,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [7:0] count,
    output logic       zero
);

    always_ff @(posedge clk) begin
        if (IORST) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/sid_bus_initiator.sv
// rtl/sid_bus_initiator.sv - one-at-a-time request to cyc/DOE/DS0_n/READ strobe sequencer
module sid_bus_initiator
    import sid_bus_pkg::*;
#(
    parameter int TIMEOUT  = SID_DEFAULT_TIMEOUT,
    parameter int RECOVERY = 1
) (
    input  logic                       clk,
    input  logic                       IORST,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [7:0]                 req_wdata,
    output logic                       rsp_valid,
    output logic [7:0]                 rsp_rdata,
    output logic                       rsp_err,
    sid_bus_initiator_if.master        bus
);

    localparam logic [7:0] TIMEOUT_U8 = sid_u8(TIMEOUT);
    localparam logic [7:0] RECOV_LOAD = sid_u8(RECOVERY - 1);

    logic [2:0] state;
    logic       wr_q;
    logic       ctr_load;
    logic [7:0] ctr_load_val;
    logic       ctr_dec;
    logic [7:0] ctr_count;
    logic       ctr_zero;

    // One counter serves both the strobe timeout and the recovery gap.
    sid_timeout_ctr u_ctr (
        .clk      (clk),
        .IORST    (IORST),
        .load     (ctr_load),
        .load_val (ctr_load_val),
        .dec      (ctr_dec),
        .count    (ctr_count),
        .zero     (ctr_zero)
    );

    always_comb begin
        ctr_load     = 1'b0;
        ctr_load_val = TIMEOUT_U8;
        ctr_dec      = 1'b0;
        case (state)
            ST_SETUP:  ctr_load = 1'b1;
            ST_STROBE: ctr_dec  = !bus.dtack;
            ST_HOLD: begin
                ctr_load     = 1'b1;
                ctr_load_val = RECOV_LOAD;
            end
            ST_RECOV:  ctr_dec  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (IORST) begin
            state     <= ST_IDLE;
            wr_q      <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= SID_CFG_RESET;
            rsp_err   <= 1'b0;
            bus.cyc   <= 1'b0;
            bus.DOE   <= 1'b0;
            bus.DS0_n <= 1'b1;
            bus.READ  <= 1'b1;
            bus.DOUT  <= 8'h00;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        wr_q      <= req_write;
                        bus.READ  <= !req_write;
                        bus.DOUT  <= req_wdata;
                        bus.cyc   <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    bus.DOE   <= 1'b1;
                    bus.DS0_n <= 1'b0;
                    state     <= ST_STROBE;
                end
                ST_STROBE: begin
                    // dtack is checked first so it wins over an expiring counter.
                    if (bus.dtack || ctr_zero) begin
                        if (bus.dtack && !wr_q) begin
                            rsp_rdata <= bus.DIN;
                        end
                        rsp_err   <= !bus.dtack;
                        rsp_valid <= 1'b1;
                        bus.DS0_n <= 1'b1;
                        bus.DOE   <= 1'b0;
                        bus.cyc   <= 1'b0;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (RECOVERY == 0) begin
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        state     <= ST_RECOV;
                    end
                end
                ST_RECOV: begin
                    if (ctr_zero) begin
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sid_bus_initiator.sv
// tb/tb_sid_bus_initiator.sv - self-checking bench for sid_bus_initiator
module tb_sid_bus_initiator;

    localparam int TO  = 15;
    localparam int REC = 1;

    logic       clk = 1'b0;
    logic       IORST;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    sid_bus_initiator_if bus ();

    sid_bus_initiator #(.TIMEOUT(TO), .RECOVERY(REC)) dut (
        .clk       (clk),
        .IORST     (IORST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Responder model: counts strobe cycles, acks after ack_dly of them.
    int         scnt;
    int         ack_dly;
    logic [7:0] din_val;
    logic       force_dtack;

    always @(posedge clk) begin
        if (bus.DS0_n) scnt <= 0;
        else           scnt <= scnt + 1;
    end

    assign bus.DIN   = din_val;
    assign bus.dtack = force_dtack | (!bus.DS0_n && (scnt == ack_dly));

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_txn(input bit wr, input logic [7:0] wd, input logic [7:0] dv,
                          input int dly, input bit hold_next);
        int  eff;
        bit  exp_err;
        int  n;
        int  strobes;
        int  lat;
        int  k;
        int  wait_cnt;
        bit  bus_bad;
        bit  rdy_bad;
        bit  gap_bad;
        eff      = (dly <= TO) ? dly : TO;
        exp_err  = (dly > TO);
        ack_dly  = dly;
        din_val  = dv;
        req_write = wr;
        req_wdata = wd;
        req_valid = 1'b1;
        wait_cnt = 0;
        while (!req_ready && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("accept_wait", 32'(req_ready), 32'd1);
        @(posedge clk);
        strobes = 0;
        lat     = -1;
        bus_bad = 1'b0;
        rdy_bad = 1'b0;
        for (n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (!hold_next) req_valid = 1'b0;
            if (rsp_valid) begin
                lat = n;
                break;
            end
            if (req_ready) rdy_bad = 1'b1;
            if (bus.READ !== !wr || bus.cyc !== 1'b1) bus_bad = 1'b1;
            if (!bus.DS0_n) begin
                strobes++;
                if (bus.DOE !== 1'b1) bus_bad = 1'b1;
                if (wr && bus.DOUT !== wd) bus_bad = 1'b1;
            end
        end
        if (!wr && !exp_err) model_rdata = dv;
        check("rsp_latency", 32'(lat), 32'(3 + eff));
        check("strobe_cycles", 32'(strobes), 32'(eff + 1));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_rdata", 32'(rsp_rdata), 32'(model_rdata));
        check("bus_during_cycle", 32'(bus_bad), 32'd0);
        check("ready_while_busy", 32'(rdy_bad), 32'd0);
        check("hold_strobes_idle", 32'({bus.cyc, bus.DOE, bus.DS0_n}), 32'b001);
        k = 0;
        gap_bad = 1'b0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (rsp_valid || bus.cyc || !bus.DS0_n) gap_bad = 1'b1;
            if (req_ready) break;
        end
        check("recovery_gap", 32'(k), 32'(REC + 1));
        check("gap_idle", 32'(gap_bad), 32'd0);
    endtask

    initial begin
        int         nbad;
        bit         w;
        logic [7:0] d;
        logic [7:0] dv;
        int         dly;
        IORST       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_wdata   = 8'h00;
        ack_dly     = 1000;
        din_val     = 8'h00;
        force_dtack = 1'b0;
        model_rdata = 8'hFF;
        repeat (3) @(negedge clk);

        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'hFF);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_cyc",       32'(bus.cyc),   32'd0);
        check("rst_DOE",       32'(bus.DOE),   32'd0);
        check("rst_DS0_n",     32'(bus.DS0_n), 32'd1);
        check("rst_READ",      32'(bus.READ),  32'd1);
        check("rst_DOUT",      32'(bus.DOUT),  32'h00);
        IORST = 1'b0;

        // Directed: write with 1-cycle ack, read with 2-cycle ack, then timeout.
        do_txn(1'b1, 8'h3C, 8'h00, 1, 1'b0);
        do_txn(1'b0, 8'h00, 8'hA5, 2, 1'b0);
        do_txn(1'b0, 8'h00, 8'h5A, 1000, 1'b0);
        // Boundary: dtack lands exactly when the counter reaches zero.
        do_txn(1'b0, 8'h00, 8'h77, TO, 1'b0);
        do_txn(1'b0, 8'h00, 8'h88, TO + 1, 1'b0);
        // Back-to-back with the next request held through the whole cycle.
        do_txn(1'b1, 8'h11, 8'h00, 1, 1'b1);
        do_txn(1'b0, 8'h00, 8'h3E, 0, 1'b1);
        do_txn(1'b1, 8'hE7, 8'h00, 1, 1'b0);

        // Stray dtack in IDLE.
        force_dtack = 1'b1;
        nbad = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || bus.cyc) nbad++;
        end
        force_dtack = 1'b0;
        check("stray_dtack", 32'(nbad), 32'd0);

        // Reset in the middle of a strobe.
        ack_dly   = 1000;
        req_write = 1'b0;
        req_valid = 1'b1;
        nbad = 0;
        while (!req_ready && nbad < 50) begin
            @(negedge clk);
            nbad++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        nbad = 0;
        while (bus.DS0_n && nbad < 10) begin
            @(negedge clk);
            nbad++;
        end
        check("reached_strobe", 32'(bus.DS0_n), 32'd0);
        repeat (3) @(negedge clk);
        IORST = 1'b1;
        @(negedge clk);
        IORST = 1'b0;
        model_rdata = 8'hFF;
        check("midrst_outputs",
              32'({bus.DS0_n, bus.cyc, bus.DOE, rsp_valid, req_ready}), 32'b10000);
        check("midrst_rdata", 32'(rsp_rdata), 32'hFF);
        do_txn(1'b0, 8'h00, 8'hC3, 2, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 16; i++) begin
            w  = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            dv = 8'($urandom);
            if ($urandom_range(0, 1) == 0) dly = w ? 1 : 2;
            else                           dly = int'($urandom_range(0, 19));
            do_txn(w, d, dv, dly, 1'($urandom_range(0, 1)));
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
